// File: rtl/ld_rs.sv
// ld_rs: load-unit reservation station; buffers LD/LDR ops, snoops the CDB,
// issues one operand-complete op per cycle and frees entries on their CDB result.
module ld_rs #(
  parameter int         NUM_ENTRIES = 4,
  parameter logic [5:0] RS_BASE     = 6'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        disp_valid,
  input  logic [3:0]  disp_op,
  input  logic        disp_rdy0,
  input  logic [5:0]  disp_tag0,
  input  logic [15:0] disp_val0,
  input  logic        disp_rdy1,
  input  logic [5:0]  disp_tag1,
  input  logic [15:0] disp_val1,
  output logic        disp_ready,
  output logic [5:0]  disp_rs_num,
  input  logic        cdb_valid,
  input  logic [5:0]  cdb_rs_num,
  input  logic [15:0] cdb_data,
  input  logic        ld_busy,
  output logic        valid,
  output logic [5:0]  rs_num,
  output logic [3:0]  op,
  output logic [15:0] val0,
  output logic [15:0] val1
);
  localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_ISSUED} state_t;
  state_t                 r_state [NUM_ENTRIES];
  state_t                 w_state_nx [NUM_ENTRIES];
  logic [3:0]             r_op [NUM_ENTRIES];
  logic                   r_rdy0 [NUM_ENTRIES];
  logic                   r_rdy1 [NUM_ENTRIES];
  logic [5:0]             r_tag0 [NUM_ENTRIES];
  logic [5:0]             r_tag1 [NUM_ENTRIES];
  logic [15:0]            r_val0 [NUM_ENTRIES];
  logic [15:0]            r_val1 [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] w_m0, w_m1, w_load;
  logic [IW-1:0]          w_free_idx, w_rdy_idx;
  logic                   w_has_free, w_has_rdy, w_accept, w_issue, w_is_ld;
  logic                   w_d_rdy0, w_d_rdy1;
  logic [15:0]            w_d_val0, w_d_val1;
  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    w_has_rdy  = 1'b0;
    w_rdy_idx  = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (r_state[i] == S_FREE) begin
        w_has_free = 1'b1;
        w_free_idx = IW'(i);
      end
      if (r_state[i] == S_READY) begin
        w_has_rdy = 1'b1;
        w_rdy_idx = IW'(i);
      end
    end
  end
  assign disp_ready  = w_has_free;
  assign disp_rs_num = RS_BASE + 6'(w_free_idx);
  assign w_accept    = disp_valid && w_has_free;
  assign w_issue     = w_has_rdy && !ld_busy;
  assign w_is_ld     = disp_op == 4'd4;
  // A dispatch waiting on the tag being broadcast this cycle captures it directly.
  assign w_d_rdy0 = disp_rdy0 || (cdb_valid && cdb_rs_num == disp_tag0);
  assign w_d_rdy1 = w_is_ld || disp_rdy1 || (cdb_valid && cdb_rs_num == disp_tag1);
  assign w_d_val0 = disp_rdy0 ? disp_val0 : cdb_data;
  assign w_d_val1 = w_is_ld ? 16'h0 : disp_rdy1 ? disp_val1 : cdb_data;
  always_comb begin
    w_m0   = '0;
    w_m1   = '0;
    w_load = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_m0[i]   = r_state[i] == S_WAIT && !r_rdy0[i] && cdb_valid && cdb_rs_num == r_tag0[i];
      w_m1[i]   = r_state[i] == S_WAIT && !r_rdy1[i] && cdb_valid && cdb_rs_num == r_tag1[i];
      w_load[i] = r_state[i] == S_FREE && w_accept && w_free_idx == IW'(i);
      w_state_nx[i] =
        w_load[i] ? ((w_d_rdy0 && w_d_rdy1) ? S_READY : S_WAIT) :
        (r_state[i] == S_WAIT && (r_rdy0[i] || w_m0[i]) && (r_rdy1[i] || w_m1[i])) ? S_READY :
        (r_state[i] == S_READY && w_issue && w_rdy_idx == IW'(i)) ? S_ISSUED :
        (r_state[i] == S_ISSUED && cdb_valid && cdb_rs_num == RS_BASE + 6'(i)) ? S_FREE :
        r_state[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_state[i] <= S_FREE;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_state[i] <= w_state_nx[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_op[i]   <= '0;
        r_rdy0[i] <= 1'b0;
        r_rdy1[i] <= 1'b0;
        r_tag0[i] <= '0;
        r_tag1[i] <= '0;
        r_val0[i] <= '0;
        r_val1[i] <= '0;
      end
      valid  <= 1'b0;
      rs_num <= '0;
      op     <= '0;
      val0   <= '0;
      val1   <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (w_load[i]) begin
          r_op[i]   <= disp_op;
          r_rdy0[i] <= w_d_rdy0;
          r_rdy1[i] <= w_d_rdy1;
          r_tag0[i] <= disp_tag0;
          r_tag1[i] <= disp_tag1;
          r_val0[i] <= w_d_val0;
          r_val1[i] <= w_d_val1;
        end else begin
          if (w_m0[i]) begin
            r_rdy0[i] <= 1'b1;
            r_val0[i] <= cdb_data;
          end
          if (w_m1[i]) begin
            r_rdy1[i] <= 1'b1;
            r_val1[i] <= cdb_data;
          end
        end
      end
      valid <= w_issue;
      if (w_issue) begin
        rs_num <= RS_BASE + 6'(w_rdy_idx);
        op     <= r_op[w_rdy_idx];
        val0   <= r_val0[w_rdy_idx];
        val1   <= r_val1[w_rdy_idx];
      end
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n) w_accept |-> (disp_op == 4'd4 || disp_op == 4'd5))
    else $error("ld_rs: illegal dispatch opcode %0d", disp_op);
endmodule

// File: tb/tb_ld_rs.sv
// tb_ld_rs: directed scenario tests for the ld_rs reservation station.
module tb_ld_rs;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        disp_valid, disp_rdy0, disp_rdy1, cdb_valid, ld_busy;
  logic [3:0]  disp_op;
  logic [5:0]  disp_tag0, disp_tag1, cdb_rs_num;
  logic [15:0] disp_val0, disp_val1, cdb_data;
  logic        disp_ready, valid;
  logic [5:0]  disp_rs_num, rs_num;
  logic [3:0]  op;
  logic [15:0] val0, val1;
  logic [42:0] w_out;
  logic [6:0]  w_disp;
  int          n_checks = 0;
  int          n_fail = 0;

  ld_rs dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_op(disp_op),
    .disp_rdy0(disp_rdy0), .disp_tag0(disp_tag0), .disp_val0(disp_val0),
    .disp_rdy1(disp_rdy1), .disp_tag1(disp_tag1), .disp_val1(disp_val1),
    .disp_ready(disp_ready), .disp_rs_num(disp_rs_num),
    .cdb_valid(cdb_valid), .cdb_rs_num(cdb_rs_num), .cdb_data(cdb_data),
    .ld_busy(ld_busy),
    .valid(valid), .rs_num(rs_num), .op(op), .val0(val0), .val1(val1)
  );

  always #5 clk = ~clk;
  assign w_out  = {valid, rs_num, op, val0, val1};
  assign w_disp = {disp_ready, disp_rs_num};

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
  endtask

  task automatic set_disp(input logic [3:0] o, input logic r0, input logic [5:0] t0,
                          input logic [15:0] v0, input logic r1, input logic [5:0] t1,
                          input logic [15:0] v1);
    disp_valid = 1'b1;
    disp_op    = o;
    disp_rdy0  = r0;
    disp_tag0  = t0;
    disp_val0  = v0;
    disp_rdy1  = r1;
    disp_tag1  = t1;
    disp_val1  = v1;
  endtask

  task automatic cdb_free(input logic [5:0] t);
    cdb_valid  = 1'b1;
    cdb_rs_num = t;
    cdb_data   = 16'h0;
    step();
    cdb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ld_busy = 1'b0;
    set_disp(4'd4, 1'b1, 6'd0, 16'h0, 1'b1, 6'd0, 16'h0);
    idle();
    cdb_rs_num = 6'd0;
    cdb_data = 16'h0;
    step();
    step();
    n_checks++;
    if (w_out !== 43'h0) begin
      n_fail++;
      $display("FAIL reset_out got %h want 0", w_out);
    end
    n_checks++;
    if (w_disp !== {1'b1, 6'd0}) begin
      n_fail++;
      $display("FAIL reset_disp got %h want %h", w_disp, {1'b1, 6'd0});
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ld_basic();
    set_disp(4'd4, 1'b1, 6'd0, 16'h0010, 1'b0, 6'd33, 16'hFFFF);
    n_checks++;
    if (w_disp !== {1'b1, 6'd0}) begin
      n_fail++;
      $display("FAIL ld_disp got %h want %h", w_disp, {1'b1, 6'd0});
    end
    step();
    idle();
    step();
    n_checks++;
    if (w_out !== {1'b1, 6'd0, 4'd4, 16'h0010, 16'h0}) begin
      n_fail++;
      $display("FAIL ld_issue got %h want %h", w_out, {1'b1, 6'd0, 4'd4, 16'h0010, 16'h0});
    end
    n_checks++;
    if (w_disp !== {1'b1, 6'd1}) begin
      n_fail++;
      $display("FAIL ld_issued_busy got %h want %h", w_disp, {1'b1, 6'd1});
    end
    step();
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ld_pulse got %b want 0", valid);
    end
    cdb_free(6'd0);
    n_checks++;
    if (w_disp !== {1'b1, 6'd0}) begin
      n_fail++;
      $display("FAIL ld_freed got %h want %h", w_disp, {1'b1, 6'd0});
    end
  endtask

  task automatic test_cdb_capture();
    set_disp(4'd5, 1'b0, 6'd9, 16'hDEAD, 1'b1, 6'd0, 16'h0003);
    step();
    idle();
    step();
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_no_issue got %b want 0", valid);
    end
    cdb_valid = 1'b1;
    cdb_rs_num = 6'd9;
    cdb_data = 16'h0100;
    step();
    cdb_valid = 1'b0;
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL capture_early got %b want 0", valid);
    end
    step();
    n_checks++;
    if (w_out !== {1'b1, 6'd0, 4'd5, 16'h0100, 16'h0003}) begin
      n_fail++;
      $display("FAIL capture_issue got %h want %h", w_out, {1'b1, 6'd0, 4'd5, 16'h0100, 16'h0003});
    end
    cdb_free(6'd0);
  endtask

  task automatic test_bypass();
    set_disp(4'd5, 1'b0, 6'd9, 16'h0000, 1'b1, 6'd0, 16'h0007);
    cdb_valid = 1'b1;
    cdb_rs_num = 6'd9;
    cdb_data = 16'hBEEF;
    step();
    idle();
    step();
    n_checks++;
    if (w_out !== {1'b1, 6'd0, 4'd5, 16'hBEEF, 16'h0007}) begin
      n_fail++;
      $display("FAIL bypass_issue got %h want %h", w_out, {1'b1, 6'd0, 4'd5, 16'hBEEF, 16'h0007});
    end
    cdb_free(6'd0);
  endtask

  task automatic test_full();
    ld_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_disp(4'd4, 1'b1, 6'd0, 16'h0100 + 16'(k), 1'b0, 6'd0, 16'h0);
      n_checks++;
      if (w_disp !== {1'b1, 6'(k)}) begin
        n_fail++;
        $display("FAIL full_disp%0d got %h want %h", k, w_disp, {1'b1, 6'(k)});
      end
      step();
    end
    set_disp(4'd4, 1'b1, 6'd0, 16'h01FF, 1'b0, 6'd0, 16'h0);
    n_checks++;
    if (disp_ready !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_state got ready=%b valid=%b want 0 0", disp_ready, valid);
    end
    step();
    idle();
    n_checks++;
    if (disp_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ignored got %b want 0", disp_ready);
    end
    ld_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (w_out !== {1'b1, 6'(k), 4'd4, 16'h0100 + 16'(k), 16'h0}) begin
        n_fail++;
        $display("FAIL full_issue%0d got %h want %h", k, w_out, {1'b1, 6'(k), 4'd4, 16'h0100 + 16'(k), 16'h0});
      end
    end
    step();
    n_checks++;
    if (valid !== 1'b0 || disp_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drained got valid=%b ready=%b want 0 0", valid, disp_ready);
    end
    cdb_free(6'd0);
    n_checks++;
    if (w_disp !== {1'b1, 6'd0}) begin
      n_fail++;
      $display("FAIL full_free0 got %h want %h", w_disp, {1'b1, 6'd0});
    end
    cdb_free(6'd1);
    cdb_free(6'd2);
    cdb_free(6'd3);
  endtask

  task automatic test_busy();
    ld_busy = 1'b1;
    set_disp(4'd4, 1'b1, 6'd0, 16'h00A0, 1'b0, 6'd0, 16'h0);
    step();
    set_disp(4'd4, 1'b1, 6'd0, 16'h00A1, 1'b0, 6'd0, 16'h0);
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (valid !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_hold%0d got %b want 0", k, valid);
      end
    end
    ld_busy = 1'b0;
    step();
    n_checks++;
    if (w_out !== {1'b1, 6'd0, 4'd4, 16'h00A0, 16'h0}) begin
      n_fail++;
      $display("FAIL busy_one got %h want %h", w_out, {1'b1, 6'd0, 4'd4, 16'h00A0, 16'h0});
    end
    ld_busy = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if (valid !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_single%0d got %b want 0", k, valid);
      end
    end
    ld_busy = 1'b0;
    step();
    n_checks++;
    if (w_out !== {1'b1, 6'd1, 4'd4, 16'h00A1, 16'h0}) begin
      n_fail++;
      $display("FAIL busy_second got %h want %h", w_out, {1'b1, 6'd1, 4'd4, 16'h00A1, 16'h0});
    end
    cdb_free(6'd0);
    cdb_free(6'd1);
  endtask

  task automatic test_async_reset();
    ld_busy = 1'b0;
    set_disp(4'd4, 1'b1, 6'd0, 16'h0030, 1'b0, 6'd0, 16'h0);
    step();
    set_disp(4'd4, 1'b1, 6'd0, 16'h0031, 1'b0, 6'd0, 16'h0);
    step();
    set_disp(4'd5, 1'b0, 6'd20, 16'h0, 1'b1, 6'd0, 16'h0005);
    step();
    idle();
    n_checks++;
    if (w_out !== {1'b1, 6'd1, 4'd4, 16'h0031, 16'h0} || w_disp !== {1'b1, 6'd3}) begin
      n_fail++;
      $display("FAIL ares_pre got out=%h disp=%h want %h %h", w_out, w_disp,
               {1'b1, 6'd1, 4'd4, 16'h0031, 16'h0}, {1'b1, 6'd3});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (w_out !== 43'h0) begin
      n_fail++;
      $display("FAIL ares_out got %h want 0", w_out);
    end
    n_checks++;
    if (w_disp !== {1'b1, 6'd0}) begin
      n_fail++;
      $display("FAIL ares_disp got %h want %h", w_disp, {1'b1, 6'd0});
    end
    cdb_valid = 1'b1;
    cdb_rs_num = 6'd20;
    cdb_data = 16'h5555;
    step();
    rst_n = 1'b1;
    step();
    cdb_free(6'd0);
    cdb_free(6'd1);
    idle();
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if (valid !== 1'b0 || w_disp !== {1'b1, 6'd0}) begin
        n_fail++;
        $display("FAIL ares_after%0d got valid=%b disp=%h want 0 %h", k, valid, w_disp, {1'b1, 6'd0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_ld_basic();
    test_cdb_capture();
    test_bypass();
    test_full();
    test_busy();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
